// File: rtl/s420_seq_ctrl_pkg.sv
// Shared types and constants for the s420 sweep controller.
// The SETTLE state only exists when S420_CTRL_SETTLE_EN is defined.
package s420_ctrl_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int SETTLE_CYC_DEF = 2;
  localparam int CMP_W          = 17;

`ifdef S420_CTRL_SETTLE_EN
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/s420_seq_ctrl_if.sv
// Command/status and datapath signals of the s420 sweep controller.
// The slave modport is the controller; master is whoever drives it.
interface s420_seq_ctrl_if
  import s420_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic [CMP_W-1:0] cfg_c;
  logic [CNT_W-1:0] max_pulses;
  logic             z_in;
  logic             p0;
  logic [CMP_W-1:0] c_out;
  logic             busy;
  logic             done;
  logic             hit;
  logic             timeout;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output start, cfg_c, max_pulses, z_in,
    input  p0, c_out, busy, done, hit, timeout, hit_cnt
  );

  modport slave (
    input  start, cfg_c, max_pulses, z_in,
    output p0, c_out, busy, done, hit, timeout, hit_cnt
  );

endinterface

// File: rtl/s420_seq_ctrl_pulse_cnt.sv
// Pulse counter for the sweep controller: clear, increment and a
// terminal compare against a caller-supplied limit.
module s420_pulse_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == limit);

endmodule

// File: rtl/s420_seq_ctrl.sv
// Sweep controller: issues count-enable pulses until the datapath reports a
// match or the pulse budget runs out. S420_CTRL_SETTLE_EN inserts settle gaps.
module s420_seq_ctrl
  import s420_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic          CK,
  input  logic          RST_N,
  s420_seq_ctrl_if.slave bus
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..15");
  end

  state_e           state;
  logic             p0_q;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CMP_W-1:0] c_q;
  logic [CNT_W-1:0] max_q;

  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_term;
  logic             cnt_clr;
  logic             cnt_inc;

`ifdef S420_CTRL_SETTLE_EN
  logic [SETTLE_W-1:0] settle_cnt;

  // Budget is checked after SETTLE, when the counter already holds the pulses issued.
  assign cnt_limit = max_q;
`else
  // Budget is checked in the RUN cycle itself, i.e. before that pulse is counted.
  assign cnt_limit = max_q - CNT_W'(1);
`endif

  assign cnt_clr = (state == S_IDLE) && bus.start;
  assign cnt_inc = (state == S_RUN);

  s420_pulse_cnt #(.CNT_W(CNT_W)) u_pulse_cnt (
    .clk   (CK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .cnt   (pulse_cnt),
    .term  (cnt_term)
  );

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      p0_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
      hit_cnt_q <= '0;
      c_q       <= '0;
      max_q     <= '0;
`ifdef S420_CTRL_SETTLE_EN
      settle_cnt <= '0;
`endif
    end else begin
      // NOTE: done defaults low here; the branches below override it only on
      // the edge entering DONE, which is what makes it a one-cycle strobe.
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            c_q       <= bus.cfg_c;
            max_q     <= bus.max_pulses;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (bus.max_pulses == '0) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end else begin
              timeout_q <= 1'b0;
              p0_q      <= 1'b1;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.z_in) begin
            hit_q     <= 1'b1;
            hit_cnt_q <= pulse_cnt;
            p0_q      <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
`ifdef S420_CTRL_SETTLE_EN
          end else begin
            p0_q       <= 1'b0;
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end
`else
          end else if (cnt_term) begin
            timeout_q <= 1'b1;
            p0_q      <= 1'b0;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end
`endif
        end
`ifdef S420_CTRL_SETTLE_EN
        S_SETTLE: begin
          if (bus.z_in) begin
            hit_q     <= 1'b1;
            hit_cnt_q <= pulse_cnt;
            done_q    <= 1'b1;
            state     <= S_DONE;
          end else if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
            if (cnt_term) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end else begin
              p0_q  <= 1'b1;
              state <= S_RUN;
            end
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
`endif
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p0      = p0_q;
  assign bus.c_out   = c_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit     = hit_q;
  assign bus.timeout = timeout_q;
  assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: doc/s420_seq_ctrl.md
S420_SEQ_CTRL -- requirements
Module: s420_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the pulse counter, max_pulses and hit_cnt.
REQ-002 SHALL have parameter SETTLE_CYC, default 2, number of settle cycles after each pulse; used only when S420_CTRL_SETTLE_EN is defined; legal range 1..15.
REQ-003 SHALL have port CK  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin one sweep; sampled only in IDLE.
REQ-006 SHALL have port cfg_c  input  17  compare vector; latched on an accepted start.
REQ-007 SHALL have port max_pulses  input  CNT_W  pulse budget; latched on an accepted start.
REQ-008 SHALL have port z_in  input  1  match flag Z returned by the counter/comparator datapath.
REQ-009 SHALL have port p0  output  1  count-enable pulse (P_0) driven to the datapath.
REQ-010 SHALL have port c_out  output  17  latched compare vector driven to C_0..C_16.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion strobe.
REQ-013 SHALL have port hit  output  1  sticky: the last sweep ended on z_in.
REQ-014 SHALL have port timeout  output  1  sticky: the last sweep exhausted its budget.
REQ-015 SHALL have port hit_cnt  output  CNT_W  pulses issued before the match; held until the next accepted start.

Function
REQ-016 SHALL implement the states IDLE, RUN, SETTLE (macro builds only) and DONE.
REQ-017 IDLE: start=1 SHALL latch cfg_c and max_pulses, clear pulse_cnt, hit, timeout and hit_cnt, and go to RUN on the next cycle.
REQ-018 In RUN, p0 SHALL be 1 for exactly the cycles spent in RUN, and pulse_cnt SHALL increment by 1 on each such cycle.
REQ-019 z_in SHALL be sampled in RUN and SETTLE; z_in=1 SHALL set hit=1, load hit_cnt with the current pulse_cnt (before increment), and go to DONE.
REQ-020 With no match and pulse_cnt+1 == max_pulses in RUN, the block SHALL set timeout=1 and go to DONE.
REQ-021 If z_in=1 and the budget is exhausted in the same cycle, hit SHALL win and timeout SHALL stay 0.
REQ-022 If max_pulses==0, the block SHALL go IDLE -> DONE directly with timeout=1 and never assert p0.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE; p0 SHALL be 0.
REQ-024 start SHALL be ignored while busy=1; a start present in the DONE cycle SHALL also be ignored.
REQ-025 pulse_cnt SHALL never wrap, because REQ-020 terminates the sweep first.
REQ-026 c_out SHALL hold its latched value through DONE and IDLE until the next accepted start.

Reset
REQ-027 RST_N=0 at a rising edge of CK SHALL force IDLE and set p0=0, busy=0, done=0, hit=0, timeout=0, hit_cnt=0, c_out=0, pulse_cnt=0 and the settle counter to 0.
REQ-028 A reset taken mid-sweep SHALL abort the sweep without producing a done strobe.

Configuration
REQ-029 The macro S420_CTRL_SETTLE_EN SHALL select the pulse timing.
REQ-030 With S420_CTRL_SETTLE_EN defined, each RUN cycle SHALL be followed by SETTLE_CYC cycles in SETTLE with p0=0, after which the block returns to RUN.
REQ-031 With the macro defined, the budget check of REQ-020 SHALL be performed at the end of SETTLE.
REQ-032 With S420_CTRL_SETTLE_EN undefined, no SETTLE state or settle counter SHALL exist, and p0 SHALL stay high on consecutive cycles in RUN.

Structure
REQ-033 Package s420_ctrl_pkg SHALL contain the state enum, CNT_W and SETTLE_CYC defaults, and the 17-bit compare-vector width constant.
REQ-034 Sub-module s420_pulse_cnt SHALL hold the saturating-free pulse counter with clear, increment and terminal-compare ports; the FSM SHALL stay in the top level.

Verification
REQ-035 Macro off, cfg_c=17'h00005, max_pulses=10, z_in=1 on the 6th p0 cycle -> done one cycle later, hit=1, hit_cnt=5, timeout=0, 6 p0 cycles in total.
REQ-036 Macro off, max_pulses=4, z_in held 0 -> exactly 4 consecutive p0 cycles, then done with timeout=1 and hit=0.
REQ-037 max_pulses=0 -> done on the 2nd cycle after start, p0 never 1, timeout=1.
REQ-038 Macro on, SETTLE_CYC=2, max_pulses=3, no match -> p0 pattern 1,0,0,1,0,0,1,0,0, then done with timeout=1.
REQ-039 start pulsed during RUN and during DONE -> ignored, c_out unchanged; RST_N=0 mid-RUN -> next cycle all outputs 0, no done strobe.
REQ-040 z_in=1 on the same cycle the budget is exhausted (max_pulses=3, z on the 3rd pulse) -> hit=1, hit_cnt=2, timeout=0.
